// File: rtl/scratchpad.sv
// scratchpad: word-addressed scratchpad memory with a fixed-latency host port and a wrapping burst-read port.
module scratchpad #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        sc_read_en,
  input  logic        sc_write_en,
  input  logic [31:0] sc_addr,
  input  logic [31:0] sc_data_in,
  output logic [31:0] sc_data_out,
  output logic        sc_ready,
  output logic        sc_err,
  input  logic        burst_req,
  input  logic [31:0] burst_addr,
  input  logic [7:0]  burst_len,
  output logic        burst_ack,
  output logic        burst_valid,
  output logic [31:0] burst_data,
  output logic        burst_last,
  input  logic        burst_ready
);
  localparam int AW = $clog2(DEPTH);
  localparam int HW = $clog2(LATENCY + 1);
  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] HOST_WAIT = 2'd1;
  localparam logic [1:0] HOST_DONE = 2'd2;
  localparam logic [1:0] BURST     = 2'd3;
  logic [1:0]    state;
  logic [31:0]   mem [DEPTH];
  logic [HW-1:0] hcnt;
  logic [7:0]    bcnt;
  logic [AW-1:0] bptr;
  logic [31:0]   rd_q;
  logic          rd_op;
  logic          host_req;
  logic          oob;
  logic          wr_ok;
  logic [AW-1:0] haddr;
  logic [31:0]   rd_next;
  always_comb begin
    host_req = sc_read_en | sc_write_en;
    oob      = sc_addr >= 32'(DEPTH);
    haddr    = AW'(sc_addr % 32'(DEPTH));
    wr_ok    = state == IDLE && sc_write_en && !oob;
    rd_next  = oob ? '0 : mem[haddr];
  end
  assign sc_ready = state == HOST_DONE;
  // memory is intentionally left unreset; writes land on the accept edge
  always_ff @(posedge clk)
    if (n_rst && wr_ok) mem[haddr] <= sc_data_in;
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      state       <= IDLE;
      hcnt        <= '0;
      bcnt        <= '0;
      bptr        <= '0;
      rd_q        <= '0;
      rd_op       <= 1'b0;
      sc_data_out <= '0;
      sc_err      <= 1'b0;
      burst_ack   <= 1'b0;
      burst_valid <= 1'b0;
      burst_last  <= 1'b0;
      burst_data  <= '0;
    end else begin
      burst_ack <= 1'b0;
      case (state)
        IDLE:
          if (host_req) begin
            rd_q  <= rd_next;
            rd_op <= !sc_write_en;
            if (oob || (sc_read_en && sc_write_en)) sc_err <= 1'b1;
            if (LATENCY == 1) begin
              state <= HOST_DONE;
              if (!sc_write_en) sc_data_out <= rd_next;
            end else begin
              state <= HOST_WAIT;
              hcnt  <= HW'(LATENCY - 1);
            end
          end else if (burst_req) begin
            burst_ack <= 1'b1;
            bptr      <= AW'(burst_addr % 32'(DEPTH));
            bcnt      <= burst_len;
            state     <= burst_len == 8'd0 ? IDLE : BURST;
          end
        HOST_WAIT:
          if (hcnt == '0) begin
            state <= HOST_DONE;
            if (rd_op) sc_data_out <= rd_q;
          end else hcnt <= hcnt - HW'(1);
        HOST_DONE: state <= IDLE;
        default:
          // a new beat is fetched only once the current one has been taken
          if (!burst_valid || burst_ready) begin
            if (bcnt == 8'd0) begin
              burst_valid <= 1'b0;
              burst_last  <= 1'b0;
              state       <= IDLE;
            end else begin
              burst_valid <= 1'b1;
              burst_data  <= mem[bptr];
              burst_last  <= bcnt == 8'd1;
              bptr        <= bptr + AW'(1);
              bcnt        <= bcnt - 8'd1;
            end
          end
      endcase
    end
endmodule

// File: tb/tb_scratchpad.sv
// tb_scratchpad: directed self-checking bench for scratchpad (DEPTH=256, LATENCY=2).
module tb_scratchpad;
  logic        clk = 1'b0;
  logic        n_rst;
  logic        sc_read_en, sc_write_en;
  logic [31:0] sc_addr, sc_data_in, sc_data_out;
  logic        sc_ready, sc_err;
  logic        burst_req, burst_ack, burst_valid, burst_last, burst_ready;
  logic [31:0] burst_addr, burst_data;
  logic [7:0]  burst_len;
  int          vecs = 0;
  int          errs = 0;
  scratchpad #(.DEPTH(256), .LATENCY(2)) dut (
    .clk(clk), .n_rst(n_rst),
    .sc_read_en(sc_read_en), .sc_write_en(sc_write_en), .sc_addr(sc_addr),
    .sc_data_in(sc_data_in), .sc_data_out(sc_data_out), .sc_ready(sc_ready), .sc_err(sc_err),
    .burst_req(burst_req), .burst_addr(burst_addr), .burst_len(burst_len), .burst_ack(burst_ack),
    .burst_valid(burst_valid), .burst_data(burst_data), .burst_last(burst_last), .burst_ready(burst_ready)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic host(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                      output int lat, output logic [31:0] dout, output logic err);
    sc_read_en = rd;
    sc_write_en = wr;
    sc_addr = a;
    sc_data_in = d;
    @(posedge clk); #1;
    lat = 0;
    while (!sc_ready && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
    dout = sc_data_out;
    err = sc_err;
    sc_read_en = 1'b0;
    sc_write_en = 1'b0;
    @(posedge clk); #1;
    chk("ready_one_cycle", {31'd0, sc_ready}, 32'd0);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    int lat, n, vcount;
    logic [31:0] dout, pd;
    logic err, pv, pr, pl;
    logic [3:0] pat;
    n_rst = 1'b0;
    sc_read_en = 1'b0;
    sc_write_en = 1'b0;
    sc_addr = '0;
    sc_data_in = '0;
    burst_req = 1'b0;
    burst_addr = '0;
    burst_len = '0;
    burst_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, sc_ready}, 32'd0);
    chk("rst_dout", sc_data_out, 32'd0);
    chk("rst_err", {31'd0, sc_err}, 32'd0);
    chk("rst_ack", {31'd0, burst_ack}, 32'd0);
    chk("rst_valid", {31'd0, burst_valid}, 32'd0);
    chk("rst_bdata", burst_data, 32'd0);
    n_rst = 1'b1;
    @(posedge clk); #1;
    host(1'b0, 1'b1, 32'd5, 32'hDEADBEEF, lat, dout, err);
    chk("wr5_latency", lat, 32'd2);
    chk("wr5_err", {31'd0, err}, 32'd0);
    host(1'b1, 1'b0, 32'd5, 32'd0, lat, dout, err);
    chk("rd5_latency", lat, 32'd2);
    chk("rd5_data", dout, 32'hDEADBEEF);
    chk("rd5_err", {31'd0, err}, 32'd0);
    host(1'b0, 1'b1, 32'd6, 32'h12345678, lat, dout, err);
    chk("wr6_dout_held", dout, 32'hDEADBEEF);
    host(1'b0, 1'b1, 32'd254, 32'hAAAA0001, lat, dout, err);
    host(1'b0, 1'b1, 32'd255, 32'hBBBB0002, lat, dout, err);
    host(1'b0, 1'b1, 32'd0, 32'hCCCC0003, lat, dout, err);
    for (int i = 0; i < 4; i++) host(1'b0, 1'b1, 32'(10 + i), 32'(32'h100 + i), lat, dout, err);
    chk("err_clean", {31'd0, sc_err}, 32'd0);
    host(1'b0, 1'b1, 32'd256, 32'hFFFFFFFF, lat, dout, err);
    chk("oob_wr_latency", lat, 32'd2);
    chk("oob_wr_err", {31'd0, err}, 32'd1);
    host(1'b1, 1'b0, 32'd0, 32'd0, lat, dout, err);
    chk("oob_wr_no_alias", dout, 32'hCCCC0003);
    host(1'b1, 1'b0, 32'd300, 32'd0, lat, dout, err);
    chk("oob_rd_latency", lat, 32'd2);
    chk("oob_rd_data", dout, 32'd0);
    chk("oob_rd_err", {31'd0, err}, 32'd1);
    host(1'b1, 1'b1, 32'd7, 32'h1, lat, dout, err);
    chk("both_err", {31'd0, err}, 32'd1);
    host(1'b1, 1'b0, 32'd7, 32'd0, lat, dout, err);
    chk("both_wrote", dout, 32'h1);
    n_rst = 1'b0;
    #1;
    chk("rst2_err", {31'd0, sc_err}, 32'd0);
    chk("rst2_dout", sc_data_out, 32'd0);
    @(posedge clk); #1;
    n_rst = 1'b1;
    @(posedge clk); #1;
    host(1'b1, 1'b0, 32'd5, 32'd0, lat, dout, err);
    chk("mem_survives_rst", dout, 32'hDEADBEEF);
    burst_addr = 32'd254;
    burst_len = 8'd3;
    burst_req = 1'b1;
    @(posedge clk); #1;
    burst_req = 1'b0;
    chk("wrap_ack", {31'd0, burst_ack}, 32'd1);
    chk("wrap_v0", {31'd0, burst_valid}, 32'd0);
    @(posedge clk); #1;
    chk("wrap_ack_gone", {31'd0, burst_ack}, 32'd0);
    chk("wrap_b0", {burst_valid, burst_last, burst_data[29:0]}, {2'b10, 30'h2AAA0001});
    @(posedge clk); #1;
    chk("wrap_b1", {burst_valid, burst_last, burst_data[29:0]}, {2'b10, 30'h3BBB0002});
    @(posedge clk); #1;
    chk("wrap_b2", {burst_valid, burst_last, burst_data[29:0]}, {2'b11, 30'h0CCC0003});
    @(posedge clk); #1;
    chk("wrap_end", {31'd0, burst_valid}, 32'd0);
    pat = 4'b1001;
    burst_addr = 32'd10;
    burst_len = 8'd4;
    burst_ready = 1'b0;
    burst_req = 1'b1;
    @(posedge clk); #1;
    burst_req = 1'b0;
    chk("bp_ack", {31'd0, burst_ack}, 32'd1);
    n = 0;
    pv = 1'b0;
    pr = 1'b0;
    pl = 1'b0;
    pd = '0;
    for (int c = 0; c < 40 && n < 4; c++) begin
      if (pv && !pr) begin
        chk("bp_hold_valid", {31'd0, burst_valid}, 32'd1);
        chk("bp_hold_data", burst_data, pd);
        chk("bp_hold_last", {31'd0, burst_last}, {31'd0, pl});
      end
      burst_ready = pat[c % 4];
      if (burst_valid && burst_ready) begin
        chk("bp_beat_data", burst_data, 32'(32'h100 + n));
        chk("bp_beat_last", {31'd0, burst_last}, {31'd0, n == 3});
        n++;
      end
      pv = burst_valid;
      pr = burst_ready;
      pd = burst_data;
      pl = burst_last;
      @(posedge clk); #1;
    end
    chk("bp_count", n, 32'd4);
    chk("bp_end", {31'd0, burst_valid}, 32'd0);
    burst_ready = 1'b1;
    burst_addr = 32'd5;
    burst_len = 8'd1;
    burst_req = 1'b1;
    host(1'b0, 1'b1, 32'd8, 32'h0000BEEF, lat, dout, err);
    chk("arb_host_first", lat, 32'd2);
    chk("arb_no_ack_yet", {31'd0, burst_ack}, 32'd0);
    @(posedge clk); #1;
    burst_req = 1'b0;
    chk("arb_ack_after", {31'd0, burst_ack}, 32'd1);
    @(posedge clk); #1;
    chk("arb_beat", {burst_valid, burst_last, burst_data[29:0]}, {2'b11, 30'h1EADBEEF});
    @(posedge clk); #1;
    chk("arb_end", {31'd0, burst_valid}, 32'd0);
    burst_addr = 32'd10;
    burst_len = 8'd4;
    burst_req = 1'b1;
    @(posedge clk); #1;
    burst_req = 1'b0;
    @(posedge clk); #1;
    host(1'b1, 1'b0, 32'd8, 32'd0, lat, dout, err);
    chk("midburst_rd_wait", lat, 32'd6);
    chk("midburst_rd_data", dout, 32'h0000BEEF);
    burst_req = 1'b1;
    @(posedge clk); #1;
    burst_req = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_burst_b2", burst_data, 32'h101);
    n_rst = 1'b0;
    #1;
    chk("rst_burst_valid", {31'd0, burst_valid}, 32'd0);
    chk("rst_burst_last", {31'd0, burst_last}, 32'd0);
    chk("rst_burst_data", burst_data, 32'd0);
    @(posedge clk); #1;
    n_rst = 1'b1;
    vcount = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (burst_valid) vcount++;
    end
    chk("rst_burst_no_beats", vcount, 32'd0);
    sc_read_en = 1'b1;
    sc_addr = 32'd5;
    @(posedge clk); #1;
    sc_read_en = 1'b0;
    n_rst = 1'b0;
    @(posedge clk); #1;
    n_rst = 1'b1;
    vcount = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (sc_ready) vcount++;
    end
    chk("rst_host_no_ready", vcount, 32'd0);
    burst_addr = 32'd0;
    burst_len = 8'd0;
    burst_req = 1'b1;
    @(posedge clk); #1;
    burst_req = 1'b0;
    chk("len0_ack", {31'd0, burst_ack}, 32'd1);
    chk("len0_v0", {31'd0, burst_valid}, 32'd0);
    @(posedge clk); #1;
    chk("len0_v1", {burst_ack, burst_valid}, 32'd0);
    host(1'b1, 1'b0, 32'd5, 32'd0, lat, dout, err);
    chk("len0_idle_latency", lat, 32'd2);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
